// File: rtl/conv_enc_pkg.sv
// Shared constants, state type and the rate-1/2 K=7 encoder equation
// used by the tail-biting convolutional encoder.
package conv_enc_pkg;

  localparam int K = 7;
  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o133;

  typedef enum logic {LOAD, ENCODE} enc_state_t;

  // Window is {b, sr1..sr6}; the tap MSB lines up with the current bit.
  function automatic logic [1:0] conv_pair(input logic b, input logic [K-2:0] sr);
    logic [K-1:0] win;
    win = {b, sr};
    return {^(win & G1), ^(win & G2)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register with tail-biting preload. Produces the coded pair
// for the bit that becomes current after this cycle's init/step update.
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [5:0] init_value,
  input  logic       step,
  input  logic       b,
  input  logic       b_nxt,
  output logic [5:0] sr,
  output logic [1:0] xy_nxt
);

  // sr[5] is sr1 (most recent bit), sr[0] is sr6.
  logic [5:0] sr_d;

  always_comb begin
    sr_d = sr;
    if (init)
      sr_d = init_value;
    else if (step)
      sr_d = {b, sr[5:1]};
  end

  assign xy_nxt = conv_pair(b_nxt, sr_d);

  always_ff @(posedge clk) begin
    if (reset)
      sr <= '0;
    else
      sr <= sr_d;
  end

endmodule

// File: rtl/tailbiting_conv_encoder.sv
// Tail-biting rate-1/2 K=7 convolutional encoder: buffers one block, preloads
// the shift register with the block's last 6 bits, then emits one pair per bit.
//
//   state  | meaning
//   LOAD   | accepting block bits into the buffer (in_ready=1)
//   ENCODE | draining coded pairs to the interleaver (out_valid=1)
module tailbiting_conv_encoder
  import conv_enc_pkg::*;
#(
  parameter int BLOCK_BITS = 96,
  parameter int CW         = $clog2(BLOCK_BITS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_xy,
  output logic       out_last,
  input  logic       out_ready
);

  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_BITS - 1);

  enc_state_t            state;
  logic [CW-1:0]         cnt;
  logic [BLOCK_BITS-1:0] buffer;

  logic          cnt_at_last;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] nxt_idx;
  logic          load_accept;
  logic          init;
  logic          step;
  logic [5:0]    init_value;
  logic [5:0]    sr;
  logic [1:0]    xy_nxt;

  assign cnt_at_last = (cnt == CNT_LAST);
  assign cnt_inc     = cnt + CW'(1);
  assign load_accept = (state == LOAD) && in_valid;
  assign init        = load_accept && cnt_at_last;
  assign step        = (state == ENCODE) && out_ready;

  // The bit accepted this cycle is not in the buffer yet, so it feeds sr1 directly.
  assign init_value  = {in_bit, buffer[BLOCK_BITS-2 -: 5]};
  assign nxt_idx     = (init || cnt_at_last) ? '0 : cnt_inc;

  always_ff @(posedge clk) begin
    if (load_accept)
      buffer[cnt] <= in_bit;
  end

  conv_enc_core u_core (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .init_value (init_value),
    .step       (step),
    .b          (buffer[cnt]),
    .b_nxt      (buffer[nxt_idx]),
    .sr         (sr),
    .xy_nxt     (xy_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_xy    <= 2'b00;
      out_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (cnt_at_last) begin
              state     <= ENCODE;
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_xy    <= xy_nxt;
              out_last  <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ENCODE: begin
          if (out_ready) begin
            if (cnt_at_last) begin
              state     <= LOAD;
              cnt       <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_xy    <= 2'b00;
              out_last  <= 1'b0;
            end else begin
              cnt      <= cnt_inc;
              out_xy   <= xy_nxt;
              out_last <= (cnt_inc == CNT_LAST);
            end
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic unused_sr;
  assign unused_sr = ^sr;

endmodule
